// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - command FIFO feeding a four-state SPI transaction sequencer
module spi_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 1023,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmdValid,
  input  logic                     cmdWrEn,
  input  logic [DATA_WIDTH-1:0]    cmdData,
  output logic                     cmdReady,
  output logic [DATA_WIDTH-1:0]    dataIn,
  output logic                     wrEn,
  output logic                     newTXN,
  input  logic                     txnDone,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifoCount,
  output logic                     timeoutErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  logic [DATA_WIDTH:0]   fifo_mem [DEPTH];
  logic [DATA_WIDTH:0]   head;

  state_t                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [GW-1:0]         gcnt_q, gcnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d;
  logic                  new_txn_q, new_txn_d;
  logic                  tout_q, tout_d;
  logic                  push, pop;

  assign head      = fifo_mem[rd_ptr_q];
  assign cmdReady  = (count_q != FULL);
  assign busy      = (state_q != S_IDLE);
  assign fifoCount = count_q;
  assign dataIn    = data_q;
  assign wrEn      = wr_q;
  assign newTXN    = new_txn_q;
  assign timeoutErr = tout_q;

  // Next-state: FIFO bookkeeping plus the IDLE/LAUNCH/WAIT/GAP sequencer
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tcnt_d    = tcnt_q;
    gcnt_d    = gcnt_q;
    data_d    = data_q;
    wr_d      = wr_q;
    new_txn_d = 1'b0;
    tout_d    = 1'b0;
    push      = cmdValid && (count_q != FULL);
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Registered count only, so a push this cycle is not seen until next cycle
        if (count_q != '0) begin
          pop     = 1'b1;
          data_d  = head[DATA_WIDTH-1:0];
          wr_d    = head[DATA_WIDTH];
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        new_txn_d = 1'b1;
        tcnt_d    = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes priority over a timeout landing on the same edge
        if (txnDone) begin
          gcnt_d  = '0;
          state_d = S_GAP;
        end else if (tcnt_q == TLAST) begin
          tout_d  = 1'b1;
          gcnt_d  = '0;
          state_d = S_GAP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: begin
        if (gcnt_q == GLAST) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State and registered outputs; reset drops the transaction and all queued commands
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tcnt_q    <= '0;
      gcnt_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      new_txn_q <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tcnt_q    <= tcnt_d;
      gcnt_q    <= gcnt_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      new_txn_q <= new_txn_d;
      tout_q    <= tout_d;
    end
  end

  // FIFO storage holds {type, data}; contents need no reset since count gates reads
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr_q] <= {cmdWrEn, cmdData};
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - directed and randomized self-checking bench for spi_cmd_sequencer
module tb_spi_cmd_sequencer;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int TOUT  = 1023;
  localparam int GAP   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmdValid = 1'b0;
  logic          cmdWrEn = 1'b0;
  logic [DW-1:0] cmdData = '0;
  logic          cmdReady;
  logic [DW-1:0] dataIn;
  logic          wrEn;
  logic          newTXN;
  logic          txnDone = 1'b0;
  logic          busy;
  logic [3:0]    fifoCount;
  logic          timeoutErr;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_launch = -1000;
  int nlaunch = 0;
  int nto = 0;
  logic [DW:0] exp_q [$];

  spi_cmd_sequencer #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TOUT), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .cmdValid(cmdValid), .cmdWrEn(cmdWrEn), .cmdData(cmdData),
    .cmdReady(cmdReady), .dataIn(dataIn), .wrEn(wrEn), .newTXN(newTXN),
    .txnDone(txnDone), .busy(busy), .fifoCount(fifoCount), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_launch(input string tag);
    int n = 0;
    while (newTXN !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check(tag, {31'd0, newTXN}, 32'd1);
  endtask

  task automatic pulse_done();
    txnDone = 1'b1;
    tick();
    txnDone = 1'b0;
  endtask

  // Transaction-level scoreboard: every accepted command must launch once, in order, spaced apart
  always @(negedge clk) begin
    logic [DW:0] e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      last_launch = -1000;
    end else begin
      if (newTXN) begin
        nlaunch++;
        if (exp_q.size() == 0) begin
          check("launch_spurious", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("launch_order", {23'd0, wrEn, dataIn}, {23'd0, e});
        end
        check("launch_spacing", {31'd0, (cyc - last_launch) >= GAP + 2}, 32'd1);
        last_launch = cyc;
      end
      if (timeoutErr) nto++;
      if (cmdValid && cmdReady) exp_q.push_back({cmdWrEn, cmdData});
    end
  end

  initial begin
    int to0;
    int nl0;
    int dly;
    int n;

    // Reset, with cmdValid held high to show it is ignored
    cmdValid = 1'b1; cmdData = 8'h55;
    tick(); tick();
    check("rst_count", fifoCount, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmdReady, 1);
    check("rst_newtxn", newTXN, 0);
    check("rst_tout", timeoutErr, 0);
    check("rst_data", dataIn, 0);
    check("rst_wren", wrEn, 0);
    rst = 1'b0; cmdValid = 1'b0;
    tick();
    check("rst_ignored_push", fifoCount, 0);

    // Single write: newTXN two edges after the push
    cmdValid = 1'b1; cmdWrEn = 1'b1; cmdData = 8'hA5;
    tick();
    cmdValid = 1'b0;
    check("sw_count_after_push", fifoCount, 1);
    check("sw_no_bypass", busy, 0);
    tick();
    check("sw_launch_busy", busy, 1);
    check("sw_launch_no_pulse_yet", newTXN, 0);
    check("sw_popped", fifoCount, 0);
    tick();
    check("sw_newtxn", newTXN, 1);
    check("sw_data", dataIn, 8'hA5);
    check("sw_wren", wrEn, 1);
    repeat (4) tick();
    check("sw_newtxn_single", newTXN, 0);
    pulse_done();
    check("sw_gap1", busy, 1);
    tick();
    check("sw_gap2", busy, 1);
    tick();
    check("sw_idle", busy, 0);
    check("sw_final_count", fifoCount, 0);
    check("sw_data_hold", dataIn, 8'hA5);

    // Fill: occupy the sequencer, then queue 0x01..0x08 and try a 9th
    cmdValid = 1'b1; cmdWrEn = 1'b0; cmdData = 8'hEE;
    tick();
    cmdValid = 1'b0;
    wait_launch("fill_dummy_launch");
    for (int i = 1; i <= 8; i++) begin
      cmdValid = 1'b1; cmdWrEn = i[0]; cmdData = i[7:0];
      tick();
      check("fill_count", fifoCount, i);
      check("fill_ready", cmdReady, (i < 8) ? 1 : 0);
    end
    cmdData = 8'h09;
    tick();
    cmdValid = 1'b0;
    check("fill_refused", fifoCount, 8);
    check("fill_refused_ready", cmdReady, 0);
    pulse_done();
    for (int i = 1; i <= 8; i++) begin
      wait_launch("fill_launch");
      check("fill_launch_data", dataIn, i);
      repeat ($urandom_range(0, 4)) tick();
      pulse_done();
    end

    // Simultaneous push and pop on the IDLE-to-LAUNCH edge with three queued
    cmdValid = 1'b1; cmdData = 8'h30;
    tick();
    cmdValid = 1'b0;
    wait_launch("pp_first_launch");
    for (int i = 1; i <= 3; i++) begin
      cmdValid = 1'b1; cmdData = 8'h30 + i[7:0];
      tick();
    end
    cmdValid = 1'b0;
    check("pp_count3", fifoCount, 3);
    pulse_done();
    tick();
    tick();
    check("pp_in_idle", busy, 0);
    cmdValid = 1'b1; cmdData = 8'h34;
    tick();
    cmdValid = 1'b0;
    check("pp_count_unchanged", fifoCount, 3);
    check("pp_launching", busy, 1);
    for (int i = 0; i < 4; i++) begin
      wait_launch("pp_drain_launch");
      pulse_done();
    end
    repeat (3) tick();
    check("pp_drained", fifoCount, 0);

    // Timeout on A, then B launches after the gap
    to0 = nto;
    cmdValid = 1'b1; cmdWrEn = 1'b1; cmdData = 8'h5A;
    tick();
    cmdWrEn = 1'b0; cmdData = 8'hC3;
    tick();
    cmdValid = 1'b0;
    wait_launch("to_launch_a");
    repeat (TOUT - 1) tick();
    check("to_not_early", timeoutErr, 0);
    tick();
    check("to_pulse", timeoutErr, 1);
    check("to_busy_gap", busy, 1);
    tick();
    check("to_pulse_one_cycle", timeoutErr, 0);
    repeat (3) tick();
    check("to_next_launch", newTXN, 1);
    check("to_next_data", dataIn, 8'hC3);
    check("to_pulse_total", nto - to0, 1);

    // txnDone in the final timeout cycle wins
    to0 = nto;
    repeat (TOUT - 1) tick();
    txnDone = 1'b1;
    tick();
    txnDone = 1'b0;
    check("co_no_tout", timeoutErr, 0);
    check("co_gap", busy, 1);
    tick();
    check("co_no_tout_late", timeoutErr, 0);
    tick();
    check("co_idle", busy, 0);
    check("co_pulse_total", nto - to0, 0);

    // Reset in WAIT with four queued
    cmdValid = 1'b1; cmdData = 8'h70;
    tick();
    cmdValid = 1'b0;
    wait_launch("rw_launch");
    for (int i = 1; i <= 4; i++) begin
      cmdValid = 1'b1; cmdData = 8'h70 + i[7:0];
      tick();
    end
    cmdValid = 1'b0;
    check("rw_count4", fifoCount, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_count", fifoCount, 0);
    check("rw_busy", busy, 0);
    check("rw_newtxn", newTXN, 0);
    check("rw_ready", cmdReady, 1);
    check("rw_data", dataIn, 0);
    to0 = nto;
    nl0 = nlaunch;
    txnDone = 1'b1;
    tick();
    txnDone = 1'b0;
    repeat (TOUT + 80) tick();
    check("rw_no_tout", nto - to0, 0);
    check("rw_no_launch", nlaunch - nl0, 0);
    check("rw_still_idle", busy, 0);

    // Randomized traffic against the scoreboard
    to0 = nto;
    dly = -1;
    for (int c = 0; c < 1500; c++) begin
      cmdValid = ($urandom_range(0, 2) == 0);
      cmdWrEn = 1'($urandom);
      cmdData = 8'($urandom);
      txnDone = (dly == 0);
      tick();
      if (dly >= 0) dly--;
      if (newTXN) dly = $urandom_range(0, 6);
    end
    cmdValid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || busy || fifoCount != 0) && n < 3000) begin
      txnDone = (dly == 0);
      tick();
      if (dly >= 0) dly--;
      if (newTXN) dly = $urandom_range(0, 6);
      n++;
    end
    txnDone = 1'b0;
    check("rnd_all_launched", exp_q.size(), 0);
    check("rnd_empty", fifoCount, 0);
    check("rnd_idle", busy, 0);
    check("rnd_no_tout", nto - to0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
